regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file. Successor to the fixed 4x32, 2-read regfile.
//  Adds per-byte write enables, optional write-to-read bypass, optional hardwired-zero entry 0,
//  and a sequential scrub (clear) engine with a busy flag.
//  Sits in the datapath between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W    32  data width in bits; must be a multiple of 8
//  ADDR_W    2   address width; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of read ports, 1..4
//  BYPASS    1   1: read of the register being written returns the merged new data in the same cycle
//  ZERO_REG  0   1: entry 0 always reads 0 and writes to it are discarded
// PORTS
//  clock      in   1              single clock; all state updates on rising edge
//  reset      in   1              synchronous, active-high
//  regwrite   in   1              write strobe
//  writereg   in   ADDR_W         write address
//  writedata  in   DATA_W         write data
//  write_be   in   DATA_W/8       byte enables; bit i covers writedata[8i+7:8i]
//  readreg    in   NUM_RD*ADDR_W  read addresses; port k = readreg[k*ADDR_W +: ADDR_W]
//  readdata   out  NUM_RD*DATA_W  read data; port k = readdata[k*DATA_W +: DATA_W]
//  clear_req  in   1              one-cycle pulse starts a sequential scrub of all entries
//  busy       out  1              high while the scrub is in progress
// BEHAVIOUR
//  Reset: clock and reset are one clock; reset is synchronous and active-high.
//   At the edge with reset=1, all entries are set to 0, state goes to IDLE, and busy goes to 0.
//   Reset overrides regwrite and clear_req. Reset during CLEAR aborts the scrub.
//  Write: at the edge with regwrite=1 and busy=0, each byte of mem[writereg] with write_be[i]=1
//   takes writedata byte i. All other bytes are kept. write_be=0 writes nothing.
//  Read: combinational and asynchronous. readdata[k] = mem[readreg[k]] with 0 cycles latency.
//   Ports are independent. Any ports may use the same address.
//  Bypass (BYPASS=1, busy=0, regwrite=1, readreg[k]==writereg): readdata[k] = merged value,
//   i.e. enabled bytes from writedata and the others from mem. BYPASS=0: readdata[k] shows the old value until after the edge.
//  Zero reg (ZERO_REG=1): address 0 reads 0 on every port, including with bypass.
//   Writes to address 0 are dropped.
//  Scrub FSM, states IDLE/CLEAR:
//   IDLE  --clear_req=1--> CLEAR. Counter ptr<=0 and busy<=1 at that edge.
//   CLEAR: each edge sets mem[ptr]<=0 and ptr<=ptr+1.
//     On the edge where ptr==DEPTH-1: state goes to IDLE and busy goes to 0.
//   The scrub takes exactly DEPTH cycles with busy=1. ptr wraps naturally and is not used in IDLE.
//   clear_req while busy=1 is ignored; it is not queued.
//   regwrite while busy=1 is dropped silently. There is no stall and no error flag; the producer gates on busy.
//   Bypass is disabled while busy=1. Reads during CLEAR return 0 for entries already scrubbed
//   and the old contents for the rest.
//  Simultaneous regwrite and clear_req in IDLE: the write commits at that edge, then the scrub starts,
//   so the written entry is cleared later.
// STRUCTURE
//  regfile_pkg: default DATA_W/ADDR_W/NUM_RD, FSM state encoding (RF_IDLE=1'b0, RF_CLEAR=1'b1),
//   and the byte-merge function merge_be(old, new, be).
//  Sub-module regfile_clear_fsm: owns state, ptr and busy. Its outputs are clr_en and clr_addr.
//  Top level: storage array, write/merge logic, NUM_RD read muxes generated in a loop, and the bypass/zero overrides.
// TESTING
//  T1 reset: write 0xDEADBEEF to r3, pulse reset -> all readdata=0 next cycle, busy=0.
//  T2 basic/byte-enable: write r1=0x11223344 (be=1111), then r1=0xAABBCCDD with be=0101
//     -> r1 reads 0x11BB33DD.
//  T3 bypass: BYPASS=1, regwrite r2=0x00600003 with readreg[0]=2 -> readdata[0]=0x00600003 in the same
//     cycle. With BYPASS=0 -> old value until after the edge.
//  T4 zero reg: ZERO_REG=1, write r0=0xFFFFFFFF -> r0 reads 0 on all ports, including the bypass cycle.
//  T5 scrub: fill r0..r3 with 1,2,3,4 and pulse clear_req -> busy high for exactly 4 cycles.
//     Mid-scrub (after 2 edges) reads r0,r1=0 and r2,r3=3,4. Writes issued during busy are lost.
//     All 0 after busy falls.
//  T6 corners: clear_req + regwrite in the same IDLE cycle -> entry ends at 0. Reset on the 2nd CLEAR cycle
//     -> busy=0 next cycle and all entries 0. clear_req while busy -> no extra cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// scrub FSM state encoding and the byte-lane merge helper.
package regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 2;
   localparam int RF_NUM_RD = 2;
   // Widest word merge_be handles; callers zero-extend narrower words
   localparam int RF_MAX_W  = 256;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   function automatic logic [RF_MAX_W-1:0] merge_be(
      input logic [RF_MAX_W-1:0]   old_v,
      input logic [RF_MAX_W-1:0]   new_v,
      input logic [RF_MAX_W/8-1:0] be
   );
      logic [RF_MAX_W-1:0] res;
      res = old_v;
      for (int i = 0; i < RF_MAX_W/8; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential scrub engine: walks every entry once after a clear request,
// presenting one address per cycle while busy.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear_req,
   output logic              o_busy,
   output logic              o_clr_en,
   output logic [ADDR_W-1:0] o_clr_addr
);

   rf_state_e         r_state;
   rf_state_e         w_next_state;
   logic [ADDR_W-1:0] r_ptr;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RF_IDLE:  if (i_clear_req) w_next_state = RF_CLEAR;
         // Last entry is cleared on this edge, so leave CLEAR together with it
         RF_CLEAR: if (r_ptr == '1) w_next_state = RF_IDLE;
         default:  w_next_state = RF_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RF_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == RF_IDLE) r_ptr <= '0;
         else                    r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_busy     = (r_state == RF_CLEAR);
   assign o_clr_en   = (r_state == RF_CLEAR);
   assign o_clr_addr = r_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD asynchronous read ports, one byte-enabled
// write port, optional write bypass, optional hardwired-zero entry 0, scrub engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,  // multiple of 8, below RF_MAX_W
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,  // 1..4
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     regwrite,
   input  logic [ADDR_W-1:0]        writereg,
   input  logic [DATA_W-1:0]        writedata,
   input  logic [DATA_W/8-1:0]      write_be,
   input  logic [NUM_RD*ADDR_W-1:0] readreg,
   output logic [NUM_RD*DATA_W-1:0] readdata,
   input  logic                     clear_req,
   output logic                     busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]          r_mem [DEPTH];
   logic                       w_busy;
   logic                       w_clr_en;
   logic [ADDR_W-1:0]          w_clr_addr;
   logic                       w_wr_live;
   logic                       w_wr_en;
   logic [DATA_W-1:0]          w_merged;
   logic [RF_MAX_W-DATA_W-1:0] w_unused_merge_hi;

   regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_clear_req (clear_req),
      .o_busy      (w_busy),
      .o_clr_en    (w_clr_en),
      .o_clr_addr  (w_clr_addr)
   );

   assign busy = w_busy;

   assign {w_unused_merge_hi, w_merged} = merge_be(
      {{(RF_MAX_W-DATA_W){1'b0}}, r_mem[writereg]},
      {{(RF_MAX_W-DATA_W){1'b0}}, writedata},
      {{((RF_MAX_W-DATA_W)/8){1'b0}}, write_be});

   // Writes arriving during a scrub are dropped; the producer gates on busy
   assign w_wr_live = regwrite && !w_busy;
   assign w_wr_en   = w_wr_live && !((ZERO_REG != 0) && (writereg == '0));

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_clr_en) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_wr_en) begin
         r_mem[writereg] <= w_merged;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_raddr;
      logic [DATA_W-1:0] w_rdata;

      assign w_raddr = readreg[k*ADDR_W +: ADDR_W];

      // Zero override is applied last so it also masks a bypassed write to entry 0
      always_comb begin
         w_rdata = r_mem[w_raddr];
         if ((BYPASS != 0) && w_wr_live && (w_raddr == writereg)) w_rdata = w_merged;
         if ((ZERO_REG != 0) && (w_raddr == '0)) w_rdata = '0;
      end

      assign readdata[k*DATA_W +: DATA_W] = w_rdata;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypass instance and one zero-reg,
// no-bypass instance share the same stimulus.
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset, regwrite, clear_req;
   logic [1:0]  writereg;
   logic [31:0] writedata;
   logic [3:0]  write_be;
   logic [3:0]  readreg;
   logic [63:0] rd_a, rd_z;
   logic        busy_a, busy_z;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mA [4];
   logic [31:0] mZ [4];

   always #5 clock = ~clock;

   regfile_mp #(.DATA_W(32), .ADDR_W(2), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
      .clock(clock), .reset(reset), .regwrite(regwrite), .writereg(writereg),
      .writedata(writedata), .write_be(write_be), .readreg(readreg),
      .readdata(rd_a), .clear_req(clear_req), .busy(busy_a));

   regfile_mp #(.DATA_W(32), .ADDR_W(2), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_z (
      .clock(clock), .reset(reset), .regwrite(regwrite), .writereg(writereg),
      .writedata(writedata), .write_be(write_be), .readreg(readreg),
      .readdata(rd_z), .clear_req(clear_req), .busy(busy_z));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] obs(int k);
      case (k)
         0:       return rd_a[31:0];
         1:       return rd_a[63:32];
         2:       return rd_z[31:0];
         default: return rd_z[63:32];
      endcase
   endfunction

   task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            mA[a][8*i +: 8] = d[8*i +: 8];
            if (a != 0) mZ[a][8*i +: 8] = d[8*i +: 8];
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin mA[i] = '0; mZ[i] = '0; end
   endtask

   task automatic sb_push(input int a0, input int a1);
      readreg = {2'(a1), 2'(a0)};
      exp_q.push_back(mA[a0]); exp_q.push_back(mA[a1]);
      exp_q.push_back(mZ[a0]); exp_q.push_back(mZ[a1]);
   endtask

   task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
      regwrite = 1'b1; writereg = 2'(a); writedata = d; write_be = be;
      step();
      regwrite = 1'b0;
      model_write(a, d, be);
   endtask

   task automatic test_reset();
      logic [31:0] e;
      do_write(3, 32'hDEADBEEF, 4'hF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_clear();
      for (int a = 0; a < 4; a += 2) begin
         sb_push(a, a + 1);
         #1;
         for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs(k) !== e) begin
               failures++;
               $display("FAIL reset_read addr%0d slot%0d got=%h exp=%h", a + k % 2, k, obs(k), e);
            end
         end
      end
      checks++;
      if (busy_a !== 1'b0 || busy_z !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b/%b exp=0", busy_a, busy_z);
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] e;
      do_write(1, 32'h11223344, 4'b1111);
      do_write(1, 32'hAABBCCDD, 4'b0101);
      readreg = {2'd1, 2'd1};
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h11BB33DD);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL byte_enable slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
      do_write(1, 32'h12345678, 4'b0000);
      sb_push(1, 0);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL be_zero slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
   endtask

   task automatic test_bypass();
      logic [31:0] e;
      regwrite = 1'b1; writereg = 2'd2; writedata = 32'h00600003; write_be = 4'hF;
      readreg = {2'd2, 2'd2};
      exp_q.push_back(32'h00600003); exp_q.push_back(32'h00600003);
      exp_q.push_back(mZ[2]);        exp_q.push_back(mZ[2]);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL bypass_full slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
      step();
      model_write(2, 32'h00600003, 4'hF);
      regwrite = 1'b1; writedata = 32'hFFFFFFFF; write_be = 4'b0010;
      exp_q.push_back(32'h0060FF03); exp_q.push_back(32'h0060FF03);
      exp_q.push_back(32'h00600003); exp_q.push_back(32'h00600003);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL bypass_merge slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
      step();
      regwrite = 1'b0;
      model_write(2, 32'hFFFFFFFF, 4'b0010);
      sb_push(2, 2);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL bypass_after slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
   endtask

   task automatic test_zero_reg();
      logic [31:0] e;
      regwrite = 1'b1; writereg = 2'd0; writedata = 32'hFFFFFFFF; write_be = 4'hF;
      readreg = {2'd0, 2'd0};
      exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFFFFFFF);
      exp_q.push_back(32'h0);        exp_q.push_back(32'h0);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL zero_bypass slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
      step();
      regwrite = 1'b0;
      model_write(0, 32'hFFFFFFFF, 4'hF);
      sb_push(0, 0);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL zero_after slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
   endtask

   task automatic test_scrub();
      logic [31:0] e;
      int cnt;
      int guard;
      for (int a = 0; a < 4; a++) do_write(a, 32'(a + 1), 4'hF);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      cnt = 0;
      checks++;
      if (busy_a !== 1'b1 || busy_z !== 1'b1) begin
         failures++;
         $display("FAIL scrub_busy_rise got=%b/%b exp=1", busy_a, busy_z);
      end
      if (busy_a) cnt++;
      regwrite = 1'b1; writereg = 2'd3; writedata = 32'h99; write_be = 4'hF;
      step();
      regwrite = 1'b0;
      if (busy_a) cnt++;
      step();
      if (busy_a) cnt++;
      mA[0] = '0; mA[1] = '0; mZ[0] = '0; mZ[1] = '0;
      for (int a = 0; a < 4; a += 2) begin
         sb_push(a, a + 1);
         #1;
         for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs(k) !== e) begin
               failures++;
               $display("FAIL scrub_mid addr%0d slot%0d got=%h exp=%h", a + k % 2, k, obs(k), e);
            end
         end
      end
      guard = 0;
      while (busy_a && guard < 20) begin
         step();
         guard++;
         if (busy_a) cnt++;
      end
      checks++;
      if (guard >= 20 || cnt != 4 || busy_z !== 1'b0) begin
         failures++;
         $display("FAIL scrub_len got=%0d exp=4 (busy_z=%b)", cnt, busy_z);
      end
      model_clear();
      for (int a = 0; a < 4; a += 2) begin
         sb_push(a, a + 1);
         #1;
         for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs(k) !== e) begin
               failures++;
               $display("FAIL scrub_done addr%0d slot%0d got=%h exp=%h", a + k % 2, k, obs(k), e);
            end
         end
      end
   endtask

   task automatic test_corners();
      logic [31:0] e;
      int cnt;
      int guard;
      regwrite = 1'b1; writereg = 2'd1; writedata = 32'h55; write_be = 4'hF;
      clear_req = 1'b1;
      step();
      regwrite = 1'b0; clear_req = 1'b0;
      cnt = busy_a ? 1 : 0;
      step();
      if (busy_a) cnt++;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      if (busy_a) cnt++;
      guard = 0;
      while (busy_a && guard < 20) begin
         step();
         guard++;
         if (busy_a) cnt++;
      end
      checks++;
      if (guard >= 20 || cnt != 4) begin
         failures++;
         $display("FAIL clear_while_busy got=%0d exp=4", cnt);
      end
      model_clear();
      sb_push(1, 1);
      #1;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(k) !== e) begin
            failures++;
            $display("FAIL write_and_clear slot%0d got=%h exp=%h", k, obs(k), e);
         end
      end
      do_write(2, 32'h77, 4'hF);
      do_write(3, 32'h88, 4'hF);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || busy_z !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort_busy got=%b/%b exp=0", busy_a, busy_z);
      end
      model_clear();
      for (int a = 0; a < 4; a += 2) begin
         sb_push(a, a + 1);
         #1;
         for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs(k) !== e) begin
               failures++;
               $display("FAIL reset_abort addr%0d slot%0d got=%h exp=%h", a + k % 2, k, obs(k), e);
            end
         end
      end
      step();
      checks++;
      if (busy_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort_stay got=%b exp=0", busy_a);
      end
   endtask

   initial begin
      reset = 1'b1; regwrite = 1'b0; clear_req = 1'b0;
      writereg = '0; writedata = '0; write_be = '0; readreg = '0;
      model_clear();
      step();
      step();
      reset = 1'b0;
      test_reset();
      test_byte_enable();
      test_bypass();
      test_zero_reg();
      test_scrub();
      test_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
